// File: rtl/vmicro16_apb_arbiter_pkg.sv
// Shared definitions for the vmicro16 APB arbiter: FSM state encodings,
// default bus widths and an index-width helper.
package vmicro16_apb_arbiter_pkg;

  localparam int DEF_CORES        = 2;
  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_TIMEOUT_CLKS = 255;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_t;

  // Width of a master index; a single master still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vmicro16_rr_pick.sv
// Combinational round-robin priority encoder: the first requester after
// 'last' (wrapping) wins. Done by rotating a doubled request vector.
module vmicro16_rr_pick
  import vmicro16_apb_arbiter_pkg::*;
#(
  parameter  int CORES = DEF_CORES,
  localparam int IDX_W = idx_w(CORES)
) (
  input  logic [CORES-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [CORES-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic [2*CORES-1:0] req_dbl;
  logic [CORES-1:0]   rot;
  logic [IDX_W:0]     start;
  logic [IDX_W:0]     off;
  logic [IDX_W:0]     pos;
  logic               req_any;

  assign req_any = |req;

  always_comb begin
    start   = ({1'b0, last} >= (IDX_W+1)'(CORES-1)) ? '0 : {1'b0, last} + (IDX_W+1)'(1);
    req_dbl = {req, req};
    // bit j of rot is master (start + j) mod CORES
    rot     = CORES'(req_dbl >> start);
    off     = '0;
    for (int j = CORES-1; j >= 0; j--) begin
      if (rot[j]) off = (IDX_W+1)'(j);
    end
    pos = start + off;
    if (pos >= (IDX_W+1)'(CORES)) pos = pos - (IDX_W+1)'(CORES);
  end

  assign idx = pos[IDX_W-1:0];

  generate
    for (genvar gi = 0; gi < CORES; gi++) begin : g_gnt
      assign gnt[gi] = req_any && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/vmicro16_apb_arbiter.sv
// Round-robin arbiter sharing one APB peripheral bus between CORES masters.
// Each grant re-drives a single SETUP/ACCESS transfer and returns the result to the winner.
module vmicro16_apb_arbiter
  import vmicro16_apb_arbiter_pkg::*;
#(
  parameter int CORES        = DEF_CORES,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CORES-1:0]        S_PSEL,
  input  logic [CORES-1:0]        S_PWRITE,
  input  logic [CORES*ADDR_W-1:0] S_PADDR,
  input  logic [CORES*DATA_W-1:0] S_PWDATA,
  output logic [DATA_W-1:0]       S_PRDATA,
  output logic [CORES-1:0]        S_PREADY,
  output logic                    S_PSLVERR,
  output logic                    M_PSEL,
  output logic                    M_PENABLE,
  output logic                    M_PWRITE,
  output logic [ADDR_W-1:0]       M_PADDR,
  output logic [DATA_W-1:0]       M_PWDATA,
  input  logic [DATA_W-1:0]       M_PRDATA,
  input  logic                    M_PREADY,
  output logic [CORES-1:0]        grant
);

  localparam int IDX_W = idx_w(CORES);
  localparam int CNT_W = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CLKS > 0) ? CNT_W'(TIMEOUT_CLKS - 1) : '0;

  arb_state_t state_reg, state_next;

  logic [IDX_W-1:0]  last_reg, last_next;
  logic [IDX_W-1:0]  win_reg, win_next;
  logic [CORES-1:0]  grant_reg, grant_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              m_psel_reg, m_psel_next;
  logic              m_penable_reg, m_penable_next;
  logic              m_pwrite_reg, m_pwrite_next;
  logic [ADDR_W-1:0] m_paddr_reg, m_paddr_next;
  logic [DATA_W-1:0] m_pwdata_reg, m_pwdata_next;
  logic [DATA_W-1:0] s_prdata_reg, s_prdata_next;
  logic [CORES-1:0]  s_pready_reg, s_pready_next;
  logic              s_pslverr_reg, s_pslverr_next;

  logic [CORES-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              req_any;
  logic              timeout_hit;
  logic              sel_pwrite;
  logic [ADDR_W-1:0] sel_paddr;
  logic [DATA_W-1:0] sel_pwdata;

  assign req_any     = |S_PSEL;
  assign timeout_hit = (TIMEOUT_CLKS != 0) && (cnt_reg == CNT_LAST);

  vmicro16_rr_pick #(.CORES(CORES)) u_pick (
    .req  (S_PSEL),
    .last (last_reg),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  // One-hot AND-OR mux of the winning master's request fields
  always_comb begin
    sel_pwrite = 1'b0;
    sel_paddr  = '0;
    sel_pwdata = '0;
    for (int i = 0; i < CORES; i++) begin
      if (pick_gnt[i]) begin
        sel_pwrite = S_PWRITE[i];
        sel_paddr  = S_PADDR[i*ADDR_W +: ADDR_W];
        sel_pwdata = S_PWDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ARB_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE:   if (req_any) state_next = ARB_SETUP;
      ARB_SETUP:  state_next = ARB_ACCESS;
      ARB_ACCESS: if (M_PREADY || timeout_hit) state_next = ARB_DONE;
      ARB_DONE:   state_next = ARB_IDLE;
      default:    state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    last_next      = last_reg;
    win_next       = win_reg;
    grant_next     = grant_reg;
    cnt_next       = cnt_reg;
    m_psel_next    = m_psel_reg;
    m_penable_next = m_penable_reg;
    m_pwrite_next  = m_pwrite_reg;
    m_paddr_next   = m_paddr_reg;
    m_pwdata_next  = m_pwdata_reg;
    s_prdata_next  = s_prdata_reg;
    s_pready_next  = s_pready_reg;
    s_pslverr_next = s_pslverr_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (req_any) begin
          win_next       = pick_idx;
          grant_next     = pick_gnt;
          m_psel_next    = 1'b1;
          m_penable_next = 1'b0;
          m_pwrite_next  = sel_pwrite;
          m_paddr_next   = sel_paddr;
          m_pwdata_next  = sel_pwdata;
        end
      end
      ARB_SETUP: begin
        m_penable_next = 1'b1;
        cnt_next       = '0;
      end
      ARB_ACCESS: begin
        // A ready slave beats a timeout expiring in the same cycle
        if (M_PREADY) begin
          s_prdata_next  = M_PRDATA;
          s_pready_next  = grant_reg;
          m_psel_next    = 1'b0;
          m_penable_next = 1'b0;
        end else if (timeout_hit) begin
          s_prdata_next  = '0;
          s_pslverr_next = 1'b1;
          s_pready_next  = grant_reg;
          m_psel_next    = 1'b0;
          m_penable_next = 1'b0;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ARB_DONE: begin
        s_pready_next  = '0;
        s_pslverr_next = 1'b0;
        grant_next     = '0;
        last_next      = win_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_reg      <= IDX_W'(CORES - 1);
      win_reg       <= '0;
      grant_reg     <= '0;
      cnt_reg       <= '0;
      m_psel_reg    <= 1'b0;
      m_penable_reg <= 1'b0;
      m_pwrite_reg  <= 1'b0;
      m_paddr_reg   <= '0;
      m_pwdata_reg  <= '0;
      s_prdata_reg  <= '0;
      s_pready_reg  <= '0;
      s_pslverr_reg <= 1'b0;
    end else begin
      last_reg      <= last_next;
      win_reg       <= win_next;
      grant_reg     <= grant_next;
      cnt_reg       <= cnt_next;
      m_psel_reg    <= m_psel_next;
      m_penable_reg <= m_penable_next;
      m_pwrite_reg  <= m_pwrite_next;
      m_paddr_reg   <= m_paddr_next;
      m_pwdata_reg  <= m_pwdata_next;
      s_prdata_reg  <= s_prdata_next;
      s_pready_reg  <= s_pready_next;
      s_pslverr_reg <= s_pslverr_next;
    end
  end

  assign grant     = grant_reg;
  assign M_PSEL    = m_psel_reg;
  assign M_PENABLE = m_penable_reg;
  assign M_PWRITE  = m_pwrite_reg;
  assign M_PADDR   = m_paddr_reg;
  assign M_PWDATA  = m_pwdata_reg;
  assign S_PRDATA  = s_prdata_reg;
  assign S_PREADY  = s_pready_reg;
  assign S_PSLVERR = s_pslverr_reg;

endmodule

// File: tb/tb_vmicro16_apb_arbiter.sv
// Randomized bench for vmicro16_apb_arbiter: masters, slave and a transaction-level
// arbitration/timing model all live here.
module tb_vmicro16_apb_arbiter;

  localparam int CORES = 2;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int TO    = 6;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [CORES-1:0]     S_PSEL, S_PWRITE;
  logic [CORES*AW-1:0]  S_PADDR;
  logic [CORES*DW-1:0]  S_PWDATA;
  logic [DW-1:0]        S_PRDATA;
  logic [CORES-1:0]     S_PREADY;
  logic                 S_PSLVERR;
  logic                 M_PSEL, M_PENABLE, M_PWRITE;
  logic [AW-1:0]        M_PADDR;
  logic [DW-1:0]        M_PWDATA, M_PRDATA;
  logic                 M_PREADY;
  logic [CORES-1:0]     grant;

  vmicro16_apb_arbiter #(
    .CORES(CORES), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .S_PSEL(S_PSEL), .S_PWRITE(S_PWRITE), .S_PADDR(S_PADDR), .S_PWDATA(S_PWDATA),
    .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
    .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PWRITE(M_PWRITE),
    .M_PADDR(M_PADDR), .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who is requesting, with what, and who was served last
  int            last_m;
  bit            pend   [CORES];
  bit            r_wr   [CORES];
  logic [AW-1:0] r_addr [CORES];
  logic [DW-1:0] r_data [CORES];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mctl"}, 32'({M_PSEL, M_PENABLE, M_PWRITE}), 32'd0);
    check({tag, "_maddr"}, 32'(M_PADDR), 32'd0);
    check({tag, "_mwdata"}, 32'(M_PWDATA), 32'd0);
    check({tag, "_sready"}, 32'({S_PREADY, S_PSLVERR}), 32'd0);
    check({tag, "_srdata"}, 32'(S_PRDATA), 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
  endtask

  task automatic drive_req();
    for (int i = 0; i < CORES; i++) begin
      S_PSEL[i]             = pend[i];
      S_PWRITE[i]           = r_wr[i];
      S_PADDR[i*AW +: AW]   = r_addr[i];
      S_PWDATA[i*DW +: DW]  = r_data[i];
    end
  endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i] = 1'b1; r_wr[i] = wr; r_addr[i] = a; r_data[i] = d;
    drive_req();
  endtask

  // First pending master after the last one served, wrapping
  function automatic int model_pick();
    for (int k = 1; k <= CORES; k++) begin
      if (pend[(last_m + k) % CORES]) return (last_m + k) % CORES;
    end
    return -1;
  endfunction

  // Entered just after the edge that starts an IDLE cycle; returns at the same point.
  task automatic run_transfer(input int wait_n, input int rd_sel, input bit do_reset);
    int            w, g, n_acc;
    bit            exp_to, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, rd;
    rd = '0;
    @(negedge clk);
    check("idle_grant", 32'(grant), 32'd0);
    check("idle_pready", 32'(S_PREADY), 32'd0);
    check("idle_psel", 32'(M_PSEL), 32'd0);
    w = model_pick();
    @(posedge clk); #1;
    if (w < 0) return;
    ea = r_addr[w]; ed = r_data[w]; ew = r_wr[w];
    // winner changes its request after grant; an idle master flashes a request
    if ($urandom_range(0, 1) == 1) begin
      r_addr[w] = AW'($urandom); r_data[w] = DW'($urandom); drive_req();
    end
    g = -1;
    for (int i = 0; i < CORES; i++) if (!pend[i]) g = i;
    if (g >= 0) begin S_PSEL[g] = 1'b1; S_PADDR[g*AW +: AW] = AW'($urandom); end
    @(negedge clk);
    check("setup_psel", 32'({M_PSEL, M_PENABLE}), 32'b10);
    check("setup_grant", 32'(grant), 32'(1 << w));
    check("setup_addr", 32'(M_PADDR), 32'(ea));
    check("setup_wdata", 32'(M_PWDATA), 32'(ed));
    check("setup_write", 32'(M_PWRITE), 32'(ew));
    @(posedge clk); #1;
    if (g >= 0) S_PSEL[g] = 1'b0;
    exp_to = (wait_n >= TO);
    n_acc  = exp_to ? TO : wait_n + 1;
    for (int a = 1; a <= n_acc; a++) begin
      M_PREADY = (a > wait_n);
      rd       = (rd_sel >= 0) ? DW'(rd_sel) : DW'($urandom);
      M_PRDATA = rd;
      if (do_reset && a == 2) reset = 1'b1;
      @(negedge clk);
      check("acc_psel", 32'({M_PSEL, M_PENABLE}), 32'b11);
      check("acc_addr", 32'(M_PADDR), 32'(ea));
      check("acc_wdata", 32'(M_PWDATA), 32'(ed));
      check("acc_pready", 32'(S_PREADY), 32'd0);
      @(posedge clk); #1;
      if (do_reset && a == 2) begin
        reset = 1'b0; M_PREADY = 1'b0;
        check_zero("rst_acc");
        last_m = CORES - 1;
        $display("XFER core=%0d addr=%h aborted by reset", w, ea);
        return;
      end
    end
    M_PREADY = 1'b0;
    @(negedge clk);
    check("done_pready", 32'(S_PREADY), 32'(1 << w));
    check("done_err", 32'(S_PSLVERR), 32'(exp_to));
    check("done_rdata", 32'(S_PRDATA), exp_to ? 32'd0 : 32'(rd));
    check("done_psel", 32'({M_PSEL, M_PENABLE}), 32'd0);
    check("done_grant", 32'(grant), 32'(1 << w));
    @(posedge clk); #1;
    pend[w] = 1'b0; last_m = w; drive_req();
    $display("XFER core=%0d wr=%0d addr=%h wdata=%h wait=%0d err=%0d rdata=%h",
             w, ew, ea, ed, wait_n, exp_to, exp_to ? '0 : rd);
  endtask

  initial begin
    bit rst;
    reset = 1'b1; M_PREADY = 1'b0; M_PRDATA = '0;
    S_PSEL = '0; S_PWRITE = '0; S_PADDR = '0; S_PWDATA = '0;
    last_m = CORES - 1;
    for (int i = 0; i < CORES; i++) begin
      pend[i] = 1'b0; r_wr[i] = 1'b0; r_addr[i] = '0; r_data[i] = '0;
    end
    drive_req();
    repeat (3) @(posedge clk);
    #1;
    check_zero("por");
    reset = 1'b0;

    // single read from core 0
    set_req(0, 1'b0, 16'h0010, 16'h0000);
    run_transfer(0, 'hBEEF, 1'b0);

    // two writers requesting continuously
    for (int k = 0; k < 4; k++) begin
      if (!pend[0]) set_req(0, 1'b1, 16'h0020, 16'h1111);
      if (!pend[1]) set_req(1, 1'b1, 16'h0022, 16'h2222);
      run_transfer(0, -1, 1'b0);
    end
    run_transfer(0, -1, 1'b0);

    // wait states: 5 (ready coincides with timeout expiry) and 3
    set_req(1, 1'b0, 16'h0030, 16'h0000);
    run_transfer(5, -1, 1'b0);
    set_req(0, 1'b0, 16'h0032, 16'h0000);
    run_transfer(3, -1, 1'b0);

    // slave never ready
    set_req(0, 1'b0, 16'h0040, 16'h0000);
    run_transfer(50, -1, 1'b0);
    run_transfer(0, -1, 1'b0);

    // reset during ACCESS with both masters pending, then core 0 goes first
    set_req(0, 1'b1, 16'h0050, 16'h5050);
    set_req(1, 1'b1, 16'h0052, 16'h5252);
    run_transfer(50, -1, 1'b1);
    run_transfer(0, -1, 1'b0);
    run_transfer(0, -1, 1'b0);

    // core 1 alone, an idle cycle, then both together
    set_req(1, 1'b0, 16'h0060, 16'h0000);
    run_transfer(1, -1, 1'b0);
    run_transfer(0, -1, 1'b0);
    set_req(0, 1'b0, 16'h0062, 16'h0000);
    set_req(1, 1'b0, 16'h0064, 16'h0000);
    run_transfer(0, -1, 1'b0);
    run_transfer(2, -1, 1'b0);

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < CORES; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      end
      rst = ($urandom_range(0, 24) == 0);
      run_transfer(rst ? 50 : int'($urandom_range(0, 8)), -1, rst);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
